// File: rtl/frac_div.sv
// Multi-cycle signed Q1.(n-1) fractional divider: result = (a << FRAC) / b.
// Restoring division, one quotient bit per cycle, then sign fix-up and saturation.
module frac_div #(
  parameter int n    = 8,
  parameter int FRAC = n - 1
) (
  input  logic                clk,
  input  logic                nReset,
  input  logic                start,
  input  logic signed [n-1:0] a,
  input  logic signed [n-1:0] b,
  output logic                busy,
  output logic                done,
  output logic signed [n-1:0] result,
  output logic                div_by_zero,
  output logic                sat
);

  localparam int QW = n + FRAC;
  localparam int CW = $clog2(QW + 1);
  localparam logic [n-1:0]  MAX_POS = {1'b0, {(n-1){1'b1}}};
  localparam logic [n-1:0]  MIN_NEG = {1'b1, {(n-1){1'b0}}};
  localparam logic [QW-1:0] POS_LIM = QW'(MAX_POS);
  localparam logic [QW-1:0] NEG_LIM = QW'(MIN_NEG);

  typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} state_t;

  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic          sign;
  logic [n-1:0]  mag_b;
  logic [n:0]    rem;
  logic [QW-1:0] quo;
  logic [n:0]    rem_sh, rem_nxt;
  logic          ge;
  logic [n:0]    fixed;

  // Unsigned magnitude; |-2^(n-1)| maps to 2^(n-1) without overflow.
  function automatic logic [n-1:0] mag(input logic [n-1:0] x);
    return x[n-1] ? (~x + 1'b1) : x;
  endfunction

  // Returns {sat, result} after sign correction and clipping.
  function automatic logic [n:0] fix_q(input logic neg, input logic [QW-1:0] q);
    logic [n-1:0] lo;
    lo = q[n-1:0];
    if (!neg) begin
      if (q > POS_LIM) return {1'b1, MAX_POS};
      return {1'b0, lo};
    end
    if (q > NEG_LIM) return {1'b1, MIN_NEG};
    return {1'b0, ~lo + 1'b1};
  endfunction

  // The quotient shift register initially holds the dividend; bits leave at
  // the MSB as quotient bits enter at the LSB.
  always_comb begin
    rem_sh  = {rem[n-1:0], quo[QW-1]};
    ge      = (rem_sh >= {1'b0, mag_b});
    rem_nxt = ge ? (rem_sh - {1'b0, mag_b}) : rem_sh;
    fixed   = fix_q(sign, quo);
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = (state == DONE);
    case (state)
      IDLE: if (start) state_nxt = (b == '0) ? DONE : DIV;
      DIV:  if (cnt == CW'(1)) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      cnt         <= '0;
      result      <= '0;
      div_by_zero <= 1'b0;
      sat         <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sat         <= 1'b0;
          div_by_zero <= 1'b0;
          cnt         <= CW'(QW);
          if (b == '0) begin
            result      <= a[n-1] ? MIN_NEG : MAX_POS;
            div_by_zero <= 1'b1;
          end
        end
        DIV: cnt <= cnt - 1'b1;
        FIX: {sat, result} <= fixed;
        default: ;
      endcase
    end
  end

  // Datapath registers carry no reset; they are always loaded at accept.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      sign  <= a[n-1] ^ b[n-1];
      mag_b <= mag(b);
      rem   <= '0;
      quo   <= {mag(a), {FRAC{1'b0}}};
    end else if (state == DIV) begin
      rem <= rem_nxt;
      quo <= {quo[QW-2:0], ge};
    end
  end

endmodule
